seq_priority_encoder: RTL and testbench

//  Registered encoder for the decoder's one-hot lines: collects request lines x into a pending set.

---
 rtl/seq_priority_encoder_if.sv | 21 ++
 rtl/seq_priority_encoder.sv | 123 ++++++++++++
 tb/tb_seq_priority_encoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seq_priority_encoder_if.sv
// Output handshake for seq_priority_encoder.
// master drives y/valid and samples ready; slave is the consumer side.
interface seq_priority_encoder_if #(
  parameter int W = 2
);
  logic [W-1:0] y;
  logic         valid;
  logic         ready;

  modport master (
    output y,
    output valid,
    input  ready
  );

  modport slave (
    input  y,
    input  valid,
    output ready
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// Registered encoder: pends one-hot events, emits their indices over valid/ready.
// Ports: clk, rst_n (sync, active-low), en, x[N], bus (y/valid/ready), ovf; macro SEQ_ENC_ROUND_ROBIN_EN.
module seq_priority_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N-1:0]          x,
  seq_priority_encoder_if.master bus,
  output logic                  ovf
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]   state_q;
  logic [0:0]   state_d;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [W-1:0] y_q;
  logic         ovf_q;

  logic [N-1:0] xin;
  logic [N-1:0] cand;
  logic [N-1:0] sel_oh;
  logic [W-1:0] sel;
  logic         valid;
  logic         slot_free;
  logic         load;
  logic         merge;

  function automatic logic [W-1:0] low_idx(
    input logic [N-1:0] v
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  assign valid     = (state_q == HOLD);
  assign xin       = en ? x : '0;
  assign cand      = pending_q | xin;
  assign slot_free = !valid || bus.ready;
  assign load      = slot_free && (|cand);
  // Line whose code sits in y is not pending, so
  // re-asserting it is a fresh event, not a merge.
  assign merge     = |(xin & pending_q);

`ifdef SEQ_ENC_ROUND_ROBIN_EN
  logic [W-1:0] rr_q;
  logic [W-1:0] rr_d;
  logic [N-1:0] hi;
  logic [N-1:0] masked;

  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      hi[i] = (W'(i) >= rr_q);
    end
  end

  // Search from rr upward; fall back to a
  // full search, which models the wrap.
  assign masked = cand & hi;
  assign sel    = (|masked) ? low_idx(masked)
                            : low_idx(cand);

  always_comb begin
    rr_d = rr_q;
    if (load) begin
      if (sel == W'(N - 1)) rr_d = '0;
      else                  rr_d = sel + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`else
  assign sel = low_idx(cand);
`endif

  assign sel_oh = N'(1) << sel;

  always_comb begin
    pending_d = cand;
    if (load) pending_d = cand & ~sel_oh;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (load) state_d = HOLD;
      HOLD:    if (bus.ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      pending_q <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load)  y_q   <= sel;
      if (merge) ovf_q <= 1'b1;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Scoreboard bench for seq_priority_encoder (N=4).
// Expected codes are queued at stimulus time; a negedge monitor checks each accepted code.
module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] x;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  logic [1:0] expq[$];
  logic [1:0] mon_e;

  always #5 clk = ~clk;

  seq_priority_encoder_if #(.W(2)) bus ();

  seq_priority_encoder #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .x     (x),
    .bus   (bus),
    .ovf   (ovf)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string nm);
    chk({nm, "_valid0"}, 32'(bus.valid), 0);
    chk({nm, "_qempty"}, 32'(expq.size()), 0);
    expq.delete();
  endtask

  // Consumer takes y on the next rising edge
  always @(negedge clk) begin
    if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_code: got %0d want none", bus.y);
      end else begin
        mon_e = expq.pop_front();
        chk("code", 32'(bus.y), 32'(mon_e));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    x         = 4'b1111;
    bus.ready = 1'b1;

    // 1: reset overrides live requests
    tick();
    tick();
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    x     = 4'b0000;
    tick();
    chk("rst_pend_empty", 32'(bus.valid), 0);

    // 2: single event, one-cycle latency
    expq.push_back(2'd2);
    x = 4'b0100;
    tick();
    x = 4'b0000;
    chk("single_valid", 32'(bus.valid), 1);
    chk("single_y", 32'(bus.y), 2);
    tick();
    drained("single");

    // 3: multi-event, lowest index first
    expq.push_back(2'd0);
    expq.push_back(2'd1);
    expq.push_back(2'd3);
    x = 4'b1011;
    tick();
    x = 4'b0000;
    repeat (3) tick();
    drained("multi");

    // 4: backpressure and overflow
    bus.ready = 1'b0;
    expq.push_back(2'd1);
    expq.push_back(2'd1);
    x = 4'b0010;
    tick();
    x = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.valid), 1);
      chk("hold_y", 32'(bus.y), 1);
      if (i < 4) tick();
    end
    x = 4'b0010;
    tick();
    x = 4'b0000;
    chk("bp_ovf_first", 32'(ovf), 0);
    chk("bp_hold_y", 32'(bus.y), 1);
    x = 4'b0010;
    tick();
    x = 4'b0000;
    chk("bp_ovf_merge", 32'(ovf), 1);
    bus.ready = 1'b1;
    tick();
    tick();
    drained("bp");
    chk("ovf_sticky", 32'(ovf), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ovf_cleared", 32'(ovf), 0);

    // 5: en=0 ignores x while draining
    bus.ready = 1'b0;
    expq.push_back(2'd0);
    x = 4'b0001;
    tick();
    expq.push_back(2'd2);
    expq.push_back(2'd3);
    x = 4'b1100;
    tick();
    en        = 1'b0;
    x         = 4'b0001;
    bus.ready = 1'b1;
    repeat (4) tick();
    drained("en0");
    chk("en0_ovf", 32'(ovf), 0);
    en = 1'b1;
    x  = 4'b0000;
    tick();

    // 6: all lines held two cycles
    expq.push_back(2'd0);
`ifdef SEQ_ENC_ROUND_ROBIN_EN
    expq.push_back(2'd1);
    expq.push_back(2'd2);
    expq.push_back(2'd3);
    expq.push_back(2'd0);
`else
    expq.push_back(2'd0);
    expq.push_back(2'd1);
    expq.push_back(2'd2);
    expq.push_back(2'd3);
`endif
    x = 4'b1111;
    tick();
    chk("all_ovf_1st", 32'(ovf), 0);
    tick();
    x = 4'b0000;
    chk("all_ovf_2nd", 32'(ovf), 1);
    repeat (5) tick();
    drained("all");

    // Reset mid-operation discards everything
    bus.ready = 1'b0;
    x = 4'b1111;
    tick();
    x = 4'b0000;
    chk("mid_valid_pre", 32'(bus.valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    chk("mid_valid_rst", 32'(bus.valid), 0);
    repeat (3) tick();
    drained("mid");
    chk("mid_ovf", 32'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
